frv_mem_responder: RTL and testbench
====================================

// Module: frv_mem_responder
// PURPOSE
//  Bus-slave memory model feeding frv_core's imem_*/dmem_* ports (one instance per port) in formal/sim benches.
//  Accepts req/gnt requests, accesses a word RAM, returns ordered recv/ack responses at bounded latency.
//  Bounds by construction: grant stall, response latency, never-unrequested response.
// PARAMETERS
//  DEPTH_LOG2      10  log2 RAM depth in 32-bit words.
//  MAX_OUTSTANDING 4   response FIFO depth, power of 2, >=1; accepted-but-unacked requests.
//  MAX_STALL       2   max consecutive cycles a pending req is denied gnt by stall_i.
//  RSP_LATENCY     1   cycles from grant to earliest mem_recv, >=1.
// PORTS
//  clock       in   1   global clock, rising edge.
//  reset       in   1   synchronous, active-high reset.
//  stall_i     in   1   bench/solver stall request; may deny gnt.
//  mem_req     in   1   core request valid.
//  mem_wen     in   1   1 = write, 0 = read.
//  mem_strb    in   4   byte write strobes.
//  mem_wdata   in   32  write data.
//  mem_addr    in   32  byte address.
//  mem_gnt     out  1   request accepted this cycle; combinational from mem_req.
//  mem_recv    out  1   response valid (FIFO head).
//  mem_ack     in   1   core accepts response.
//  mem_error   out  1   response carries bus error.
//  mem_rdata   out  32  response read data; 0 for writes/errors.
//  outstanding out  $clog2(MAX_OUTSTANDING+1)  accepted, not yet acked.
// BEHAVIOUR
//  Reset: mem_gnt=0, mem_recv=0, mem_error=0, mem_rdata=0, outstanding=0.
//  Reset also clears FIFO pointers and stall_cnt. RAM contents are not reset.
//  Reset mid-operation discards all queued responses; no recv in cycle after reset deasserts.
//  Grant: mem_gnt = mem_req && !reset && !full && (!stall_i || stall_cnt==MAX_STALL).
//   full means outstanding==MAX_OUTSTANDING. Full blocks gnt even if head pops same cycle.
//   stall_cnt counts consecutive cycles with mem_req && !mem_gnt && !full.
//   stall_cnt clears on gnt, or on !mem_req; saturates at MAX_STALL.
//  Access happens in the grant cycle.
//   Error when addr[1:0]!=0 or addr[31:2] >= 2**DEPTH_LOG2.
//   Write, no error: RAM[addr[DEPTH_LOG2+1:2]] byte lanes with strb[i]=1 take wdata lane i at clock edge.
//   Write with error: not committed.
//   Read: data sampled from RAM before any same-cycle write; 0 when error.
//  Each grant pushes {error, rdata, age=0} to FIFO tail. Entry ages saturate at RSP_LATENCY.
//  mem_recv=1 iff FIFO non-empty and head age>=RSP_LATENCY, so earliest recv is cycle grant+RSP_LATENCY.
//  Head holds recv/error/rdata stable until mem_ack; pops on mem_recv && mem_ack.
//  When not recv, mem_error=0 and mem_rdata=0.
//  Responses are strictly in grant order. mem_ack while !mem_recv is ignored.
//  outstanding += gnt, -= (recv&&ack). Both in one cycle -> unchanged.
//  Pointers wrap modulo MAX_OUTSTANDING; full/empty come from count, not pointer compare.
//  Invariants (asserted in block): outstanding<=MAX_OUTSTANDING; recv -> outstanding>0;
//   stall_cnt<=MAX_STALL.
// TESTING
//  1 Reset then read addr 0x10 after write 0xDEADBEEF strb 0xF, RSP_LATENCY=1, ack held high.
//    -> gnt same cycle; recv exactly 1 cycle later; rdata=0xDEADBEEF; error=0.
//  2 Write 0x11223344 strb 0x5 over 0xFFFFFFFF, then read same address -> rdata=0xFF22FF44.
//  3 stall_i=1 constantly with mem_req high, MAX_STALL=2 -> gnt denied 2 cycles, granted in 3rd.
//  4 Four back-to-back reads, ack low -> outstanding=4, 5th req not granted.
//    Ack once -> head pops; 5th granted the following cycle. Responses arrive in order.
//  5 Read addr 0x2 and read addr 2**(DEPTH_LOG2+2) -> both recv with error=1, rdata=0.
//    Erroring write leaves RAM unchanged.
//  6 Assert reset with 3 responses queued -> recv=0, outstanding=0 next cycle; no stale response later.

Source files
------------

// File: rtl/frv_mem_responder.sv
// Word-RAM bus slave answering req/gnt requests with in-order recv/ack responses.
// Latency: gnt is combinational from mem_req; earliest mem_recv is RSP_LATENCY cycles after gnt.
// Backpressure: gnt withheld when MAX_OUTSTANDING responses are unacked or stall_i (bounded by MAX_STALL).
module frv_mem_responder #(
  parameter int DEPTH_LOG2      = 10,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_STALL       = 2,
  parameter int RSP_LATENCY     = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 stall_i,
  input  logic                                 mem_req,
  input  logic                                 mem_wen,
  input  logic [3:0]                           mem_strb,
  input  logic [31:0]                          mem_wdata,
  input  logic [31:0]                          mem_addr,
  output logic                                 mem_gnt,
  output logic                                 mem_recv,
  input  logic                                 mem_ack,
  output logic                                 mem_error,
  output logic [31:0]                          mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW    = $clog2(RSP_LATENCY + 1);
  localparam int SW    = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

  logic [31:0]           ram       [DEPTH];
  logic [31:0]           rsp_rdata [MAX_OUTSTANDING];
  logic                  rsp_error [MAX_OUTSTANDING];
  logic [AW-1:0]         rsp_age   [MAX_OUTSTANDING];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [SW-1:0]         stall_cnt;
  logic                  full;
  logic                  empty;
  logic                  addr_err;
  logic                  pop;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           rd_word;

  // Occupancy comes from the counter so pointer equality never has to disambiguate full/empty.
  assign full     = (outstanding == CW'(MAX_OUTSTANDING));
  assign empty    = (outstanding == '0);
  assign addr_err = (mem_addr[1:0] != 2'b00) || (mem_addr[31:DEPTH_LOG2+2] != '0);
  assign word_idx = mem_addr[DEPTH_LOG2+1:2];
  // Read sees the RAM before any write committed at the same edge.
  assign rd_word  = addr_err ? 32'h0 : ram[word_idx];

  // Full blocks the grant even if the head pops this cycle, keeping gnt independent of mem_ack.
  assign mem_gnt   = mem_req && !reset && !full && (!stall_i || stall_cnt == SW'(MAX_STALL));
  assign mem_recv  = !reset && !empty && (rsp_age[head] >= AW'(RSP_LATENCY));
  assign mem_error = mem_recv && rsp_error[head];
  assign mem_rdata = mem_recv ? rsp_rdata[head] : 32'h0;
  assign pop       = mem_recv && mem_ack;

  // RAM byte-lane write on an accepted, error-free write; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_gnt && mem_wen && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_strb[i]) ram[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Response storage: push at tail on grant; every entry ages, saturating at RSP_LATENCY.
  // A pushed entry already counts its grant cycle, so it is visible RSP_LATENCY cycles later.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (mem_gnt && tail == PW'(i)) begin
        rsp_error[i] <= addr_err;
        rsp_rdata[i] <= rd_word;
        rsp_age[i]   <= AW'(1);
      end else if (rsp_age[i] < AW'(RSP_LATENCY)) begin
        rsp_age[i]   <= rsp_age[i] + AW'(1);
      end
    end
  end

  // Pointers, occupancy and the stall bound; reset drops every queued response.
  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      outstanding <= '0;
      stall_cnt   <= '0;
    end else begin
      if (mem_gnt) tail <= (tail == PW'(MAX_OUTSTANDING - 1)) ? '0 : tail + PW'(1);
      if (pop)     head <= (head == PW'(MAX_OUTSTANDING - 1)) ? '0 : head + PW'(1);
      outstanding <= outstanding + CW'(mem_gnt) - CW'(pop);
      if (mem_gnt || !mem_req) begin
        stall_cnt <= '0;
      end else if (!full && stall_cnt != SW'(MAX_STALL)) begin
        stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end

  a_outstanding_bound: assert property (@(posedge clock) disable iff (reset)
    outstanding <= CW'(MAX_OUTSTANDING));
  a_recv_requested: assert property (@(posedge clock) disable iff (reset)
    mem_recv |-> (outstanding != '0));
  a_stall_bound: assert property (@(posedge clock) disable iff (reset)
    stall_cnt <= SW'(MAX_STALL));

endmodule

// File: tb/tb_frv_mem_responder.sv
// Bench for frv_mem_responder: directed scenarios plus random traffic against a queue-based model.
// The model predicts gnt/recv/data/outstanding every cycle from the grant and latency rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_frv_mem_responder;

  localparam int DL  = 10;
  localparam int MO  = 4;
  localparam int MS  = 2;
  localparam int LAT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        mem_req;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding;

  frv_mem_responder #(
    .DEPTH_LOG2(DL), .MAX_OUTSTANDING(MO), .MAX_STALL(MS), .RSP_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset), .stall_i(stall_i), .mem_req(mem_req),
    .mem_wen(mem_wen), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_recv(mem_recv),
    .mem_ack(mem_ack), .mem_error(mem_error), .mem_rdata(mem_rdata),
    .outstanding(outstanding)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          gcyc;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ram_m [1024];
  rsp_t        q [$];
  int          cyc = 0;
  int          stall_m = 0;
  logic [31:0] last_rd = 32'h0;
  logic        last_err = 1'b0;
  logic        last_gnt = 1'b0;
  int          obs_pops = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic req, input logic wen, input logic [3:0] strb,
                       input logic [31:0] wdata, input logic [31:0] addr);
    mem_req   = req;
    mem_wen   = wen;
    mem_strb  = strb;
    mem_wdata = wdata;
    mem_addr  = addr;
  endtask

  // One clock: compare DUT against model, then advance the model at the edge.
  task automatic cycle();
    bit          eg, er, full, aerr;
    logic        ee;
    logic [31:0] ed;
    rsp_t        r;
    @(negedge clock);
    full = (q.size() == MO);
    eg   = !reset && mem_req && !full && (!stall_i || stall_m == MS);
    er   = !reset && q.size() > 0 && cyc >= q[0].gcyc + LAT;
    ee   = er ? q[0].err : 1'b0;
    ed   = er ? q[0].dat : 32'h0;
    check("gnt", 32'(mem_gnt), 32'(eg));
    check("recv", 32'(mem_recv), 32'(er));
    check("error", 32'(mem_error), 32'(ee));
    check("rdata", mem_rdata, ed);
    check("outstanding", 32'(outstanding), 32'(q.size()));
    last_gnt = mem_gnt;
    if (mem_recv && mem_ack) obs_pops++;
    @(posedge clock);
    if (reset) begin
      q.delete();
      stall_m = 0;
    end else begin
      if (er && mem_ack) begin
        last_rd  = q[0].dat;
        last_err = q[0].err;
        void'(q.pop_front());
      end
      if (eg) begin
        aerr   = (mem_addr % 4 != 0) || ((mem_addr / 4) >= 1024);
        r.err  = aerr;
        r.dat  = aerr ? 32'h0 : ram_m[mem_addr / 4];
        r.gcyc = cyc;
        q.push_back(r);
        if (mem_wen && !aerr) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_strb[b]) ram_m[mem_addr / 4][8*b +: 8] = mem_wdata[8*b +: 8];
          end
        end
      end
      if (eg || !mem_req) stall_m = 0;
      else if (!full && stall_m < MS) stall_m++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int pops_before;
    logic [31:0] a;
    reset   = 1'b1;
    stall_i = 1'b0;
    mem_ack = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    cycle();
    cycle();
    check("reset_outstanding", 32'(outstanding), 32'd0);
    reset = 1'b0;

    // Give the first 16 words defined contents.
    for (int w = 0; w < 16; w++) begin
      drive(1'b1, 1'b1, 4'hF, $urandom, 32'(w * 4));
      cycle();
    end
    idle(2);

    // Write then read back with immediate ack.
    drive(1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 32'h10);
    cycle();
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h10);
    cycle();
    check("t1_gnt", 32'(last_gnt), 32'd1);
    idle(2);
    check("t1_rdata", last_rd, 32'hDEADBEEF);
    check("t1_error", 32'(last_err), 32'd0);

    // Partial strobe merge.
    drive(1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h20);
    cycle();
    drive(1'b1, 1'b1, 4'h5, 32'h11223344, 32'h20);
    cycle();
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h20);
    cycle();
    idle(2);
    check("t2_rdata", last_rd, 32'hFF22FF44);

    // Constant stall: two denials then a grant.
    stall_i = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check(k < 2 ? "t3_deny" : "t3_gnt", 32'(last_gnt), k < 2 ? 32'd0 : 32'd1);
    end
    stall_i = 1'b0;
    idle(2);

    // Fill to MAX_OUTSTANDING with ack low, then a single ack frees one slot.
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 4'h0, 32'h0, 32'(k * 4));
      cycle();
    end
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h30);
    cycle();
    check("t4_full_deny", 32'(last_gnt), 32'd0);
    check("t4_outstanding", 32'(outstanding), 32'd4);
    mem_ack = 1'b1;
    cycle();
    check("t4_pop_same_cycle_deny", 32'(last_gnt), 32'd0);
    mem_ack = 1'b0;
    cycle();
    check("t4_fifth_gnt", 32'(last_gnt), 32'd1);
    mem_ack = 1'b1;
    idle(6);

    // Misaligned and out-of-range reads, then an erroring write.
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h2);
    cycle();
    idle(2);
    check("t5_misaligned_err", 32'(last_err), 32'd1);
    check("t5_misaligned_rdata", last_rd, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h1000);
    cycle();
    idle(2);
    check("t5_range_err", 32'(last_err), 32'd1);
    drive(1'b1, 1'b1, 4'hF, 32'h0, 32'h12);
    cycle();
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h10);
    cycle();
    idle(2);
    check("t5_ram_unchanged", last_rd, 32'hDEADBEEF);

    // Reset with responses queued.
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'h0, 32'h0, 32'(k * 4));
      cycle();
    end
    idle(1);
    check("t6_queued", 32'(outstanding), 32'd3);
    reset = 1'b1;
    cycle();
    reset   = 1'b0;
    mem_ack = 1'b1;
    pops_before = obs_pops;
    idle(4);
    check("t6_no_stale", 32'(obs_pops - pops_before), 32'd0);

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      reset   = ($urandom_range(199) == 0);
      stall_i = ($urandom_range(2) == 0);
      mem_ack = $urandom_range(1);
      case ($urandom_range(9))
        0:       a = 32'($urandom_range(15) * 4) | 32'($urandom_range(3));
        1:       a = $urandom | 32'h1000;
        default: a = 32'($urandom_range(15) * 4);
      endcase
      drive($urandom_range(3) != 0, $urandom_range(1), 4'($urandom), $urandom, a);
      cycle();
    end
    reset = 1'b0;
    mem_ack = 1'b1;
    idle(8);
    check("final_drain", 32'(outstanding), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
